// File: rtl/video_pkg.sv
// Shared encodings for the video test-pattern generator: mode codes,
// frame-counter width and the 3-bit colour-bar table.
package video_pkg;

   typedef enum logic [1:0] {
      MODE_BARS  = 2'd0,
      MODE_CHECK = 2'd1,
      MODE_RAMP  = 2'd2,
      MODE_BOX   = 2'd3
   } mode_t;

   localparam int FRAME_CNT_W = 16;
   localparam int BAR_IDX_W   = 3;
   localparam int POS_W       = 13;

   // {R,G,B} one bit per channel; expanded to full scale by replication
   function automatic logic [2:0] bar_code(input logic [BAR_IDX_W-1:0] idx);
      logic [2:0] code;
      // NOTE: defaulting first keeps combinational functions latch-free
      code = 3'b000;
      case (idx)
         3'd0: code = 3'b111;   // white
         3'd1: code = 3'b110;   // yellow
         3'd2: code = 3'b011;   // cyan
         3'd3: code = 3'b010;   // green
         3'd4: code = 3'b101;   // magenta
         3'd5: code = 3'b100;   // red
         3'd6: code = 3'b001;   // blue
         default: code = 3'b000; // black
      endcase
      return code;
   endfunction

endpackage

// File: rtl/video_box_mover.sv
// Bouncing-box position state: moves BOX_STEP per axis on each frame_end
// strobe and reflects off the active-area edges.
module video_box_mover
   import video_pkg::*;
#(
   parameter int H_DISP   = 1920,
   parameter int V_DISP   = 1080,
   parameter int BOX_SIZE = 64,
   parameter int BOX_STEP = 4
) (
   input  logic             pixel_clk,
   input  logic             sys_rst,
   input  logic             frame_end,
   output logic [POS_W-1:0] box_x,
   output logic [POS_W-1:0] box_y
);

   localparam int AW = POS_W + 2;
   localparam logic [AW-1:0] STEP_A = AW'(BOX_STEP);
   localparam logic [AW-1:0] SIZE_A = AW'(BOX_SIZE);
   localparam logic [AW-1:0] LIM_X  = AW'(H_DISP);
   localparam logic [AW-1:0] LIM_Y  = AW'(V_DISP);

   logic             dir_x_neg, dir_y_neg;
   logic             next_dx, next_dy;
   logic [POS_W-1:0] next_x, next_y;

   // Returns {direction_negative, position} after one frame step
   function automatic logic [POS_W:0] next_axis(input logic [POS_W-1:0] pos,
                                                input logic             neg,
                                                input logic [AW-1:0]    limit);
      logic [AW-1:0]    pos_a;
      logic [POS_W-1:0] res;
      logic             dir;
      pos_a = AW'(pos);
      res   = pos;
      dir   = neg;
      if (!neg) begin
         if (pos_a + STEP_A + SIZE_A > limit) begin
            res = POS_W'(limit - SIZE_A);
            dir = 1'b1;
         end else begin
            res = POS_W'(pos_a + STEP_A);
         end
      end else begin
         if (pos_a < STEP_A) begin
            res = '0;
            dir = 1'b0;
         end else begin
            res = POS_W'(pos_a - STEP_A);
         end
      end
      return {dir, res};
   endfunction

   always_comb begin
      {next_dx, next_x} = next_axis(box_x, dir_x_neg, LIM_X);
      {next_dy, next_y} = next_axis(box_y, dir_y_neg, LIM_Y);
   end

   always_ff @(posedge pixel_clk or posedge sys_rst) begin
      if (sys_rst) begin
         box_x     <= '0;
         box_y     <= '0;
         dir_x_neg <= 1'b0;
         dir_y_neg <= 1'b0;
      end else if (frame_end) begin
         // NOTE: non-blocking so all four updates see the pre-edge state
         box_x     <= next_x;
         box_y     <= next_y;
         dir_x_neg <= next_dx;
         dir_y_neg <= next_dy;
      end
   end

endmodule

// File: rtl/video_pattern_gen.sv
// Multi-mode test-pattern source (bars/checker/ramp/box), 2-cycle latency.
// Define VIDEO_PATTERN_BORDER_EN to add a 1-pixel white border over every mode.
module video_pattern_gen
   import video_pkg::*;
#(
   parameter int H_DISP     = 1920,
   parameter int V_DISP     = 1080,
   parameter int COLOR_W    = 8,
   parameter int NUM_BARS   = 8,
   parameter int CHECK_LOG2 = 6,
   parameter int BOX_SIZE   = 64,
   parameter int BOX_STEP   = 4
) (
   input  logic                   pixel_clk,
   input  logic                   sys_rst,
   input  logic [POS_W-1:0]       pixel_xpos,
   input  logic [POS_W-1:0]       pixel_ypos,
   input  logic                   pixel_de_in,
   input  logic [1:0]             mode_sel,
   output logic [3*COLOR_W-1:0]   pixel_data,
   output logic                   pixel_de_out,
   output logic [FRAME_CNT_W-1:0] frame_cnt
);

   localparam int BAR_W = H_DISP / NUM_BARS;
   localparam logic [POS_W-1:0]     BAR_LAST    = POS_W'(BAR_W - 1);
   localparam logic [BAR_IDX_W-1:0] BAR_IDX_MAX = BAR_IDX_W'(NUM_BARS - 1);
   localparam logic [POS_W-1:0]     X_LAST      = POS_W'(H_DISP - 1);
   localparam logic [POS_W-1:0]     Y_LAST      = POS_W'(V_DISP - 1);

   logic first_pixel, frame_end;
   logic [POS_W-1:0] box_x, box_y;

   logic [POS_W-1:0]     bar_cnt, bar_cnt_eff;
   logic [BAR_IDX_W-1:0] bar_idx, bar_idx_eff;

   mode_t                active_mode;
   logic                 s1_de, s1_chk, s1_in_box;
   logic [BAR_IDX_W-1:0] s1_bar;
   logic [COLOR_W-1:0]   s1_ramp;
   logic                 in_box;
   logic [2:0]           code;
   logic [3*COLOR_W-1:0] colour;
`ifdef VIDEO_PATTERN_BORDER_EN
   logic                 s1_border;
`endif

   assign first_pixel = pixel_de_in && (pixel_xpos == '0) && (pixel_ypos == '0);
   assign frame_end   = pixel_de_in && (pixel_xpos == X_LAST) && (pixel_ypos == Y_LAST);

   video_box_mover #(
      .H_DISP   (H_DISP),
      .V_DISP   (V_DISP),
      .BOX_SIZE (BOX_SIZE),
      .BOX_STEP (BOX_STEP)
   ) u_box (
      .pixel_clk (pixel_clk),
      .sys_rst   (sys_rst),
      .frame_end (frame_end),
      .box_x     (box_x),
      .box_y     (box_y)
   );

   // Column 0 restarts the bar count regardless of what the last line left behind
   always_comb begin
      bar_cnt_eff = (pixel_xpos == '0) ? '0 : bar_cnt;
      bar_idx_eff = (pixel_xpos == '0) ? '0 : bar_idx;
      in_box = ({1'b0, pixel_xpos} >= {1'b0, box_x}) &&
               ({1'b0, pixel_xpos} <  {1'b0, box_x} + (POS_W+1)'(BOX_SIZE)) &&
               ({1'b0, pixel_ypos} >= {1'b0, box_y}) &&
               ({1'b0, pixel_ypos} <  {1'b0, box_y} + (POS_W+1)'(BOX_SIZE));
   end

   always_ff @(posedge pixel_clk or posedge sys_rst) begin
      if (sys_rst) begin
         bar_cnt <= '0;
         bar_idx <= '0;
      end else if (pixel_de_in) begin
         if (bar_cnt_eff == BAR_LAST) begin
            bar_cnt <= '0;
            bar_idx <= (bar_idx_eff == BAR_IDX_MAX) ? BAR_IDX_MAX
                                                    : bar_idx_eff + BAR_IDX_W'(1);
         end else begin
            bar_cnt <= bar_cnt_eff + POS_W'(1);
            bar_idx <= bar_idx_eff;
         end
      end
   end

   // Stage 1: register DE, per-pixel region decode, mode latch, frame count
   always_ff @(posedge pixel_clk or posedge sys_rst) begin
      if (sys_rst) begin
         s1_de       <= 1'b0;
         s1_chk      <= 1'b0;
         s1_in_box   <= 1'b0;
         s1_bar      <= '0;
         s1_ramp     <= '0;
         active_mode <= MODE_BARS;
         frame_cnt   <= '0;
`ifdef VIDEO_PATTERN_BORDER_EN
         s1_border   <= 1'b0;
`endif
      end else begin
         s1_de     <= pixel_de_in;
         s1_chk    <= pixel_xpos[CHECK_LOG2] ^ pixel_ypos[CHECK_LOG2];
         s1_in_box <= in_box;
         s1_bar    <= bar_idx_eff;
         s1_ramp   <= COLOR_W'(pixel_xpos);
`ifdef VIDEO_PATTERN_BORDER_EN
         s1_border <= (pixel_xpos == '0) || (pixel_xpos == X_LAST) ||
                      (pixel_ypos == '0) || (pixel_ypos == Y_LAST);
`endif
         if (first_pixel)
            active_mode <= mode_t'(mode_sel);
         if (frame_end)
            frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
      end
   end

   always_comb begin
      case (active_mode)
         MODE_BARS:  code = bar_code(s1_bar);
         MODE_CHECK: code = s1_chk ? 3'b000 : 3'b111;
         MODE_BOX:   code = s1_in_box ? 3'b100 : 3'b001;
         default:    code = 3'b000;
      endcase
      colour = {{COLOR_W{code[2]}}, {COLOR_W{code[1]}}, {COLOR_W{code[0]}}};
      if (active_mode == MODE_RAMP)
         colour = {3{s1_ramp}};
`ifdef VIDEO_PATTERN_BORDER_EN
      if (s1_border)
         colour = '1;
`endif
   end

   // Stage 2: register colour, blanked whenever the aligned DE is low
   always_ff @(posedge pixel_clk or posedge sys_rst) begin
      if (sys_rst) begin
         pixel_data   <= '0;
         pixel_de_out <= 1'b0;
      end else begin
         pixel_data   <= s1_de ? colour : '0;
         pixel_de_out <= s1_de;
      end
   end

endmodule

// File: tb/tb_video_pattern_gen.sv
// Directed bench for video_pattern_gen: two instances (8 and 3 bars) share
// stimulus; a scoreboard queue holds expected pixels until the 2-cycle output.
module tb_video_pattern_gen;

   localparam int H    = 64;
   localparam int V    = 16;
   localparam int BSZ  = 8;
   localparam int BSTP = 5;

   logic        pixel_clk = 1'b0;
   logic        sys_rst   = 1'b0;
   logic [12:0] pixel_xpos = '0;
   logic [12:0] pixel_ypos = '0;
   logic        pixel_de_in = 1'b0;
   logic [1:0]  mode_sel = 2'd0;

   logic [23:0] data_a, data_b;
   logic        de_a, de_b;
   logic [15:0] fc_a, fc_b;

   video_pattern_gen #(.H_DISP(H), .V_DISP(V), .COLOR_W(8), .NUM_BARS(8),
                       .CHECK_LOG2(2), .BOX_SIZE(BSZ), .BOX_STEP(BSTP)) dut_a (
      .pixel_clk(pixel_clk), .sys_rst(sys_rst), .pixel_xpos(pixel_xpos),
      .pixel_ypos(pixel_ypos), .pixel_de_in(pixel_de_in), .mode_sel(mode_sel),
      .pixel_data(data_a), .pixel_de_out(de_a), .frame_cnt(fc_a));

   video_pattern_gen #(.H_DISP(H), .V_DISP(V), .COLOR_W(8), .NUM_BARS(3),
                       .CHECK_LOG2(2), .BOX_SIZE(BSZ), .BOX_STEP(BSTP)) dut_b (
      .pixel_clk(pixel_clk), .sys_rst(sys_rst), .pixel_xpos(pixel_xpos),
      .pixel_ypos(pixel_ypos), .pixel_de_in(pixel_de_in), .mode_sel(mode_sel),
      .pixel_data(data_b), .pixel_de_out(de_b), .frame_cnt(fc_b));

   always #5 pixel_clk = ~pixel_clk;

   typedef struct {
      logic [23:0] a;
      logic [23:0] b;
      logic        de;
   } exp_t;

   exp_t sb[$];
   int total = 0;
   int bad   = 0;

   int          m_mode;
   int          m_bx, m_by;
   bit          m_dxn, m_dyn;
   logic [15:0] m_fc;

   task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp_v);
      total++;
      assert (obs === exp_v) else begin
         bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
      end
   endtask

   function automatic logic [23:0] expand(input logic [2:0] c);
      return {{8{c[2]}}, {8{c[1]}}, {8{c[0]}}};
   endfunction

   function automatic logic [2:0] bar_rgb(input int i);
      case (i)
         0: return 3'b111;
         1: return 3'b110;
         2: return 3'b011;
         3: return 3'b010;
         4: return 3'b101;
         5: return 3'b100;
         6: return 3'b001;
         default: return 3'b000;
      endcase
   endfunction

   function automatic logic [23:0] model_px(input int x, input int y, input int nb);
      int bw, idx;
      logic [12:0] xv, yv;
      logic [23:0] px;
      xv = 13'(x);
      yv = 13'(y);
      px = 24'h0;
      case (m_mode)
         0: begin
            bw  = H / nb;
            idx = x / bw;
            if (idx > nb - 1) idx = nb - 1;
            px = expand(bar_rgb(idx));
         end
         1: px = (xv[2] ^ yv[2]) ? 24'h000000 : 24'hFFFFFF;
         2: px = {3{xv[7:0]}};
         default: begin
            if (x >= m_bx && x < m_bx + BSZ && y >= m_by && y < m_by + BSZ)
               px = 24'hFF0000;
            else
               px = 24'h0000FF;
         end
      endcase
`ifdef VIDEO_PATTERN_BORDER_EN
      if (x == 0 || x == H - 1 || y == 0 || y == V - 1) px = 24'hFFFFFF;
`endif
      return px;
   endfunction

   task automatic move_axis(inout int pos, inout bit neg, input int limit);
      if (!neg) begin
         if (pos + BSTP + BSZ > limit) begin
            pos = limit - BSZ;
            neg = 1'b1;
         end else begin
            pos = pos + BSTP;
         end
      end else begin
         if (pos < BSTP) begin
            pos = 0;
            neg = 1'b0;
         end else begin
            pos = pos - BSTP;
         end
      end
   endtask

   task automatic model_reset();
      m_mode = 0;
      m_bx = 0; m_by = 0;
      m_dxn = 1'b0; m_dyn = 1'b0;
      m_fc = '0;
      sb.delete();
   endtask

   // One pixel cycle: drive, push expectation, then compare the output due now
   task automatic step(input int x, input int y, input bit de, input logic [1:0] ms);
      exp_t e;
      @(negedge pixel_clk);
      pixel_xpos  = 13'(x);
      pixel_ypos  = 13'(y);
      pixel_de_in = de;
      mode_sel    = ms;
      if (de && x == 0 && y == 0) m_mode = int'(ms);
      e.a  = de ? model_px(x, y, 8) : 24'h0;
      e.b  = de ? model_px(x, y, 3) : 24'h0;
      e.de = de;
      sb.push_back(e);
      if (de && x == H - 1 && y == V - 1) begin
         m_fc = m_fc + 16'd1;
         move_axis(m_bx, m_dxn, H);
         move_axis(m_by, m_dyn, V);
      end
      @(posedge pixel_clk);
      #1;
      check("frame_cnt_a", {8'h0, fc_a}, {8'h0, m_fc});
      check("frame_cnt_b", {8'h0, fc_b}, {8'h0, m_fc});
      if (sb.size() == 2) begin
         e = sb.pop_front();
         check("pixel_data_8bars", data_a, e.a);
         check("pixel_data_3bars", data_b, e.b);
         check("pixel_de_out", {23'h0, de_a}, {23'h0, e.de});
      end
   endtask

   task automatic line(input int y, input logic [1:0] ms);
      for (int x = 0; x < H; x++) step(x, y, 1'b1, ms);
      step(H, y, 1'b0, ms);
      step(H + 1, y, 1'b0, ms);
   endtask

   task automatic frame(input logic [1:0] ms);
      for (int y = 0; y < V; y++) line(y, ms);
   endtask

   initial begin
      model_reset();
      #1 sys_rst = 1'b1;
      #1;
      check("reset_data", data_a, 24'h0);
      check("reset_de", {23'h0, de_a}, 24'h0);
      check("reset_frame_cnt", {8'h0, fc_a}, 24'h0);
      @(negedge pixel_clk);
      sys_rst = 1'b0;

      // Bars, then a mid-frame switch to checker at line 5, then checker
      frame(2'd0);
      for (int y = 0; y < V; y++) line(y, (y < 5) ? 2'd0 : 2'd1);
      frame(2'd1);

      // Grey ramp, plus an out-of-range column that must still wrap
      frame(2'd2);
      step(300, 3, 1'b1, 2'd2);
      step(0, 0, 1'b0, 2'd2);
      step(0, 0, 1'b0, 2'd2);

      // Mid-line asynchronous reset while checker is active
      line(0, 2'd1);
      line(1, 2'd1);
      for (int x = 0; x < 21; x++) step(x, 2, 1'b1, 2'd1);
      sys_rst = 1'b1;
      #1;
      check("async_rst_data", data_a, 24'h0);
      check("async_rst_de", {23'h0, de_a}, 24'h0);
      check("async_rst_frame_cnt", {8'h0, fc_a}, 24'h0);
      model_reset();
      @(negedge pixel_clk);
      sys_rst = 1'b0;

      // Mode stays bars until the next first pixel even though checker is selected
      line(3, 2'd1);
      line(4, 2'd3);

      // Three box frames from a fresh reset: box_y runs 0, 5, 8
      frame(2'd3);
      frame(2'd3);
      frame(2'd3);
      step(0, 0, 1'b0, 2'd3);
      step(0, 0, 1'b0, 2'd3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/video_pattern_gen.md
Name: video_pattern_gen

Overview:
- Parametrised multi-mode test-pattern source for the VGA/HDMI output path; sits between the timing generator (pixel_xpos/pixel_ypos/DE) and the transmitter (e.g. MS7210 RGB input).
- Successor to the fixed five-bar generator: configurable colour depth, bar count and resolution; four runtime-selectable patterns, including an animated bouncing box.
- Registered DE alignment and a frame counter.

Parameters:
- H_DISP, 1920, active pixels per line
- V_DISP, 1080, active lines per frame
- COLOR_W, 8, bits per channel; pixel_data is 3*COLOR_W wide, ordered {R,G,B}
- NUM_BARS, 8, colour-bar count, 1..8
- CHECK_LOG2, 6, checkerboard square side = 2^CHECK_LOG2 pixels
- BOX_SIZE, 64, bouncing-box side in pixels; must be less than H_DISP and less than V_DISP
- BOX_STEP, 4, box displacement per frame per axis; must be at least 1

Ports:
- pixel_clk, in, 1, pixel clock
- sys_rst, in, 1, reset; asynchronous, active-high
- pixel_xpos, in, 13, active-area column from the timing generator
- pixel_ypos, in, 13, active-area row from the timing generator
- pixel_de_in, in, 1, active-video enable, aligned with xpos/ypos
- mode_sel, in, 2, pattern select: 0 bars, 1 checker, 2 grey ramp, 3 box
- pixel_data, out, 3*COLOR_W, RGB pixel
- pixel_de_out, out, 1, pixel_de_in delayed to align with pixel_data
- frame_cnt, out, 16, completed-frame counter

Behaviour:
- Reset (async assert, sync release): all outputs 0; active mode = 0; box at (0,0) with direction +x,+y; bar counters 0.
- Latency: exactly 2 pixel_clk cycles from inputs to pixel_data/pixel_de_out.
  - Stage 1 registers coords/DE and decodes region.
  - Stage 2 registers colour.
- pixel_data = 0 whenever the aligned DE is 0.
- Mode latch: mode_sel is sampled into the active mode only on the first active pixel (pixel_de_in=1, xpos=0, ypos=0). A mid-frame mode change takes effect at the next frame.
- Frame end: the cycle with pixel_de_in=1, xpos=H_DISP-1, ypos=V_DISP-1.
  - frame_cnt increments by 1 and wraps 0xFFFF to 0.
  - Box position updates.
- Bars: BAR_W = H_DISP/NUM_BARS (integer division).
  - Division-free: a pixel counter and bar index are cleared when xpos=0.
  - Counter increments per active pixel; at BAR_W-1 it clears and the index increments.
  - The index saturates at NUM_BARS-1, so the last bar absorbs the remainder.
  - Colour table, index 0..7: white, yellow, cyan, green, magenta, red, blue, black. Each channel is full-scale (all ones) or 0.
- Checker: white where xpos[CHECK_LOG2] XOR ypos[CHECK_LOG2] = 0, else black.
- Grey ramp: all three channels = xpos[COLOR_W-1:0]; wraps every 2^COLOR_W pixels.
- Box:
  - Pixels inside [box_x, box_x+BOX_SIZE) x [box_y, box_y+BOX_SIZE) are red; all other pixels are blue.
  - Per axis at frame end, moving +: if pos+BOX_STEP+BOX_SIZE > limit, clamp pos to limit-BOX_SIZE and flip direction; otherwise pos += BOX_STEP.
  - Moving −: if pos < BOX_STEP, clamp to 0 and flip direction; otherwise pos −= BOX_STEP.
  - limit = H_DISP for x, V_DISP for y.
- Coordinates at or beyond H_DISP/V_DISP with DE=1 are treated as in range by the arithmetic; no checking is done.
- Reset mid-frame: output goes to 0 immediately. Patterns resume at the next first active pixel.

Optional Feature:
- Macro: VIDEO_PATTERN_BORDER_EN.
- Defined: a 1-pixel white border (xpos=0, xpos=H_DISP-1, ypos=0, ypos=V_DISP-1) overrides every mode. It is applied in stage 2, so latency is unchanged.
- Undefined: no border logic; patterns are output unmodified.

Decomposition:
- Shared package video_pkg:
  - pattern mode encodings (MODE_BARS, MODE_CHECK, MODE_RAMP, MODE_BOX)
  - 8-entry bar colour table as 3-bit RGB codes, expanded to COLOR_W by replication
  - frame-counter width constant
- One natural sub-module: video_box_mover. It holds box_x/box_y/direction state and takes a frame_end strobe; the parent instantiates it.

Test Plan:
- Use H_DISP=64, V_DISP=16, COLOR_W=8, NUM_BARS=8, mode 0 → BAR_W=8. xpos 0..7 gives FFFFFF, 8..15 gives FFFF00, 56..63 gives 000000; outputs appear 2 cycles after input.
- Use NUM_BARS=3 with H_DISP=64 → BAR_W=21. xpos 42..63 (22 px) are all cyan 00FFFF.
- Mode 2, xpos=300 → pixel_data=2C2C2C. pixel_de_in=0 → pixel_data=000000 and pixel_de_out=0.
- Switch mode_sel 0→1 at mid-frame line 5 → rest of the frame stays bars; the next frame is checker, with CHECK_LOG2=2 at (4,0) giving 000000.
- Mode 3 with BOX_SIZE=8, BOX_STEP=5, H_DISP=64, V_DISP=16, run 3 frames → box_y sequence 0,5,8 with direction flipped; frame_cnt=3.
- Assert sys_rst mid-line → pixel_data, pixel_de_out and frame_cnt go to 0 asynchronously, without waiting for a clock edge. After release, the mode returns to bars until the next frame start.
